uart_msg_sequencer: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter among up to N_REQ key-triggered message requesters. Each request selects a message (base address, length) in a byte ROM; the block fetches the bytes one at a time and streams them to the UART TX via a valid/ready handshake. It sits between the debounced key pulses and the existing uart_tx, generalising the single-key "send birthday string" path to several keys and messages.

---
 rtl/uart_msg_sequencer_if.sv | 22 ++
 rtl/uart_msg_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_uart_msg_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_sequencer_if.sv
// ROM read port and UART TX byte handshake seen by the message sequencer.
// master = sequencer side, slave = ROM / uart_tx side.
interface uart_msg_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rom_rd, rom_addr, tx_data, tx_valid,
        input  rom_data, tx_ready
    );

    modport slave (
        input  rom_rd, rom_addr, tx_data, tx_valid,
        output rom_data, tx_ready
    );
endinterface

// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: round-robin sharing of one UART TX byte port between
// N_REQ key-triggered requesters. Each served request streams msg_len bytes
// starting at msg_base out of a synchronous byte ROM, one byte at a time.

// One requester's sticky pending flag.
module uart_msg_pend_cell (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic pend
);
    // A pulse landing in the same cycle as the grant-clear wins, so it is re-queued.
    always_ff @(posedge clk) begin
        if (rst)      pend <= 1'b0;
        else if (set) pend <= 1'b1;
        else if (clr) pend <= 1'b0;
    end
endmodule

module uart_msg_sequencer #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] msg_base,
    input  logic [N_REQ*LEN_W-1:0]  msg_len,
    uart_msg_sequencer_if.master    bus,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    done
);
    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  pending;
    logic [N_REQ-1:0]  clr;
    logic [ADDR_W-1:0] base_arr [N_REQ];
    logic [LEN_W-1:0]  len_arr  [N_REQ];
    logic [IDX_W-1:0]  rr;       // round-robin start point
    logic [IDX_W-1:0]  win;      // arbitration winner this cycle
    logic [IDX_W-1:0]  cur;      // requester currently being served
    logic              any_pend;
    logic              hs;
    logic              rom_rd_c;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [7:0]        tx_data_r;
    logic              tx_valid_r;

    // (base + k) mod N_REQ without relying on N_REQ being a power of two.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= N_REQ) j = j - N_REQ;
        return j[IDX_W-1:0];
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign base_arr[i] = msg_base[i*ADDR_W +: ADDR_W];
        assign len_arr[i]  = msg_len[i*LEN_W +: LEN_W];

        uart_msg_pend_cell u_pend (
            .clk  (clk),
            .rst  (rst),
            .set  (req[i]),
            .clr  (clr[i]),
            .pend (pending[i])
        );
    end

    // Round-robin pick: scan downwards so the lowest offset from rr is the last writer.
    always_comb begin
        win      = '0;
        any_pend = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pending[rot_idx(rr, k)]) begin
                win      = rot_idx(rr, k);
                any_pend = 1'b1;
            end
        end
    end

    // Only a byte presented in SEND can be consumed; tx_ready elsewhere is ignored.
    assign hs = (state == SEND) && tx_valid_r && bus.tx_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        rom_rd_c  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        clr       = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_pend) begin
                    clr       = onehot(win);
                    state_nxt = (len_arr[win] == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rom_rd_c  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: state_nxt = SEND;
            SEND: begin
                if (hs) state_nxt = (rem == LEN_W'(1)) ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Message datapath: grant/pointer bookkeeping, byte address and remaining count, TX holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            rr         <= '0;
            cur        <= '0;
            addr       <= '0;
            rem        <= '0;
            tx_data_r  <= '0;
            tx_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        grant <= onehot(win);
                        cur   <= win;
                        addr  <= base_arr[win];
                        rem   <= len_arr[win];
                    end
                end
                WAIT: begin
                    // ROM data is valid the cycle after the read strobe.
                    tx_data_r  <= bus.rom_data;
                    tx_valid_r <= 1'b1;
                end
                SEND: begin
                    if (hs) begin
                        tx_valid_r <= 1'b0;
                        addr       <= addr + 1'b1;
                        rem        <= rem - 1'b1;
                    end
                end
                DONE: begin
                    grant <= '0;
                    rr    <= (cur == LAST_IDX) ? '0 : cur + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_rd   = rom_rd_c;
    assign bus.rom_addr = rom_rd_c ? addr : '0;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_valid = tx_valid_r;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Bench for uart_msg_sequencer: directed scenarios plus a randomized run,
// with a scoreboard that predicts winners, ROM addresses and TX bytes.
module tb_uart_msg_sequencer;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int LW = 6;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] msg_base;
    logic [N*LW-1:0] msg_len;
    logic [N-1:0]    grant;
    logic            busy;
    logic            done;

    uart_msg_sequencer_if #(.ADDR_W(AW)) bus ();

    uart_msg_sequencer #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .msg_base (msg_base),
        .msg_len  (msg_len),
        .bus      (bus),
        .grant    (grant),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] rom [256];
    int cfg_base [N];
    int cfg_len  [N];
    int total = 0;
    int bad   = 0;

    // Synchronous ROM: data one cycle after the read strobe.
    always @(posedge clk) if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];

    // Reference model state.
    bit         m_pend [N];
    int         m_rr = 0, m_cur = 0;
    int         q_bytes[$];
    int         q_addr[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [N-1:0] prev_grant = '0;
    logic       prev_done  = 1'b0;
    int hs_cnt = 0, done_cnt = 0, grant_cnt = 0;
    int sb_w, sb_j, sb_v;
    logic [N-1:0] sb_eg;

    // Scoreboard, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_rr = 0; m_cur = 0;
            q_bytes.delete(); q_addr.delete();
        end else begin
            if (prev_grant == '0 && grant != '0) begin
                sb_w = -1;
                for (int k = 0; k < N; k++) begin
                    sb_j = (m_rr + k) % N;
                    if (sb_w < 0 && m_pend[sb_j]) sb_w = sb_j;
                end
                total++; grant_cnt++;
                if (sb_w < 0) begin
                    bad++; $display("FAIL sb_spurious_grant: got %b, nothing pending", grant);
                end else begin
                    sb_eg = 4'(1) << sb_w;
                    if (grant !== sb_eg) begin
                        bad++; $display("FAIL sb_winner: got %b expected %b", grant, sb_eg);
                    end
                    m_pend[sb_w] = 1'b0; m_cur = sb_w;
                    for (int b = 0; b < cfg_len[sb_w]; b++) begin
                        q_addr.push_back((cfg_base[sb_w] + b) % 256);
                        q_bytes.push_back(int'(rom[(cfg_base[sb_w] + b) % 256]));
                    end
                end
            end else if (prev_grant != '0 && grant !== prev_grant) begin
                total++;
                if (!(prev_done && grant == '0)) begin
                    bad++; $display("FAIL sb_grant_change: got %b expected %b", grant, prev_grant);
                end
            end
            if (bus.rom_rd) begin
                total++;
                if (q_addr.size() == 0) begin
                    bad++; $display("FAIL sb_extra_read: got addr %02h, none expected", bus.rom_addr);
                end else begin
                    sb_v = q_addr.pop_front();
                    if (bus.rom_addr !== sb_v[7:0]) begin
                        bad++; $display("FAIL sb_rom_addr: got %02h expected %02h", bus.rom_addr, sb_v[7:0]);
                    end
                end
            end
            if (prev_valid && bus.tx_ready) begin
                hs_cnt++; total++;
                if (q_bytes.size() == 0) begin
                    bad++; $display("FAIL sb_extra_byte: got %02h, none expected", prev_data);
                end else begin
                    sb_v = q_bytes.pop_front();
                    if (prev_data !== sb_v[7:0]) begin
                        bad++; $display("FAIL sb_tx_byte: got %02h expected %02h", prev_data, sb_v[7:0]);
                    end
                end
            end else if (prev_valid) begin
                total++;
                if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
                    bad++; $display("FAIL sb_stall_hold: got v=%b d=%02h expected v=1 d=%02h", bus.tx_valid, bus.tx_data, prev_data);
                end
            end
            if (done) begin
                done_cnt++; total++;
                sb_eg = 4'(1) << m_cur;
                if (q_bytes.size() != 0 || grant !== sb_eg) begin
                    bad++; $display("FAIL sb_done: got grant=%b left=%0d expected grant=%b left=0", grant, q_bytes.size(), sb_eg);
                end
                m_rr = (m_cur + 1) % N;
            end
            for (int i = 0; i < N; i++) if (req[i]) m_pend[i] = 1'b1;
        end
        prev_valid = bus.tx_valid; prev_data = bus.tx_data;
        prev_grant = grant;        prev_done = done;
    end

    task automatic set_cfg(input int i, input int base, input int len);
        cfg_base[i] = base; cfg_len[i] = len;
        msg_base[i*AW +: AW] = AW'(base);
        msg_len[i*LW +: LW]  = LW'(len);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        @(negedge clk); req = m;
        @(negedge clk); req = '0;
    endtask

    task automatic wait_grant(input int max, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < max && !ok; t++) begin
            @(negedge clk);
            if (grant != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_clear(input int max, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < max && !ok; t++) begin
            @(negedge clk);
            if (grant == '0) ok = 1'b1;
        end
    endtask

    // Idle means busy low for three consecutive cycles.
    task automatic wait_idle(input int max, output bit ok);
        int run;
        run = 0; ok = 1'b0;
        for (int t = 0; t < max && !ok; t++) begin
            @(negedge clk);
            run = busy ? 0 : run + 1;
            if (run >= 3) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (grant !== '0)          begin bad++; $display("FAIL rst_grant: got %b expected 0", grant); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0)         begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b expected 0", bus.tx_valid); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %02h expected 00", bus.tx_data); end
        total++; if (bus.rom_rd !== 1'b0)   begin bad++; $display("FAIL rst_rom_rd: got %b expected 0", bus.rom_rd); end
        total++; if (bus.rom_addr !== 8'h00) begin bad++; $display("FAIL rst_rom_addr: got %02h expected 00", bus.rom_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int hs0, dn0;
        set_cfg(0, 'h10, 3); bus.tx_ready = 1'b1;
        hs0 = hs_cnt; dn0 = done_cnt;
        @(negedge clk); req = 4'b0001;
        @(negedge clk); req = '0;
        total++; if (grant !== '0 || busy !== 1'b0) begin bad++; $display("FAIL single_c1: got grant=%b busy=%b expected 0/0", grant, busy); end
        @(negedge clk);
        total++; if (grant !== 4'b0001 || busy !== 1'b1 || bus.rom_rd !== 1'b1 || bus.rom_addr !== 8'h10)
            begin bad++; $display("FAIL single_c2: got grant=%b busy=%b rd=%b addr=%02h expected 0001/1/1/10", grant, busy, bus.rom_rd, bus.rom_addr); end
        @(negedge clk);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL single_c3_valid: got %b expected 0", bus.tx_valid); end
        @(negedge clk);
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h32)
            begin bad++; $display("FAIL single_c4: got v=%b d=%02h expected 1/32", bus.tx_valid, bus.tx_data); end
        for (int c = 5; c <= 11; c++) begin
            @(negedge clk);
            total++; if (done !== (c == 11) || grant !== 4'b0001)
                begin bad++; $display("FAIL single_c%0d: got done=%b grant=%b expected done=%0d grant=0001", c, done, grant, c == 11); end
        end
        @(negedge clk);
        total++; if (grant !== '0 || busy !== 1'b0) begin bad++; $display("FAIL single_end: got grant=%b busy=%b expected 0/0", grant, busy); end
        total++; if (hs_cnt - hs0 != 3 || done_cnt - dn0 != 1)
            begin bad++; $display("FAIL single_counts: got hs=%0d done=%0d expected 3/1", hs_cnt - hs0, done_cnt - dn0); end
    endtask

    task automatic test_backpressure();
        int hs0, dn0;
        bit ok;
        logic [7:0] d;
        bus.tx_ready = 1'b0; hs0 = hs_cnt; dn0 = done_cnt;
        pulse(4'b0001);
        for (int b = 0; b < 3; b++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                if (bus.tx_valid) ok = 1'b1;
            end
            d = bus.tx_data;
            total++; if (!ok || d !== rom[16 + b]) begin bad++; $display("FAIL bp_byte%0d: got ok=%b d=%02h expected %02h", b, ok, d, rom[16 + b]); end
            repeat (50) @(negedge clk);
            total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== d)
                begin bad++; $display("FAIL bp_hold%0d: got v=%b d=%02h expected 1/%02h", b, bus.tx_valid, bus.tx_data, d); end
            bus.tx_ready = 1'b1;
            @(negedge clk); bus.tx_ready = 1'b0;
        end
        wait_idle(20, ok);
        total++; if (!ok || hs_cnt - hs0 != 3 || done_cnt - dn0 != 1)
            begin bad++; $display("FAIL bp_counts: got idle=%b hs=%0d done=%0d expected 1/3/1", ok, hs_cnt - hs0, done_cnt - dn0); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        set_cfg(1, 'h20, 2); set_cfg(3, 'h30, 1); bus.tx_ready = 1'b1;
        pulse(4'b1010);
        wait_grant(10, ok);
        total++; if (!ok || grant !== 4'b0010) begin bad++; $display("FAIL sim_first: got %b expected 0010", grant); end
        wait_clear(30, ok);
        wait_grant(10, ok);
        total++; if (!ok || grant !== 4'b1000) begin bad++; $display("FAIL sim_second: got %b expected 1000", grant); end
        wait_idle(40, ok);
        // Pointer has wrapped back to 0, so an all-ones request starts at requester 0.
        set_cfg(0, 'h10, 1); set_cfg(2, 'h40, 2);
        pulse(4'b1111);
        wait_grant(10, ok);
        total++; if (!ok || grant !== 4'b0001) begin bad++; $display("FAIL sim_rr_wrap: got %b expected 0001", grant); end
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL sim_drain: got busy=%b expected idle", busy); end
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_idx [4] = '{0, 2, 0, 2};
        logic [N-1:0] eg;
        set_cfg(0, 'h10, 2); set_cfg(2, 'h40, 2); bus.tx_ready = 1'b1;
        pulse(4'b0101);
        for (int g = 0; g < 4; g++) begin
            wait_grant(20, ok);
            eg = 4'(1) << exp_idx[g];
            total++; if (!ok || grant !== eg) begin bad++; $display("FAIL fair_order%0d: got %b expected %b", g, grant, eg); end
            if (g < 3) begin
                pulse((g == 1) ? 4'b0101 : 4'b0001);
                if (g == 0) pulse(4'b0001);
            end
            wait_clear(40, ok);
        end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL fair_drain: got busy=%b expected idle", busy); end
    endtask

    task automatic test_edge();
        bit ok;
        int hs0;
        int addrs[$];
        int ea;
        set_cfg(1, 'h50, 0); bus.tx_ready = 1'b1;
        pulse(4'b0010);
        @(negedge clk);
        total++; if (grant !== 4'b0010 || done !== 1'b1 || bus.rom_rd !== 1'b0 || bus.tx_valid !== 1'b0)
            begin bad++; $display("FAIL len0_c2: got grant=%b done=%b rd=%b v=%b expected 0010/1/0/0", grant, done, bus.rom_rd, bus.tx_valid); end
        @(negedge clk);
        total++; if (grant !== '0 || done !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL len0_c3: got grant=%b done=%b busy=%b expected 0/0/0", grant, done, busy); end
        set_cfg(3, 'hFE, 4); hs0 = hs_cnt;
        pulse(4'b1000);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.rom_rd) addrs.push_back(int'(bus.rom_addr));
        end
        total++; if (addrs.size() != 4 || hs_cnt - hs0 != 4)
            begin bad++; $display("FAIL wrap_count: got reads=%0d hs=%0d expected 4/4", addrs.size(), hs_cnt - hs0); end
        for (int i = 0; i < 4 && i < addrs.size(); i++) begin
            ea = (254 + i) % 256;
            total++; if (addrs[i] != ea) begin bad++; $display("FAIL wrap_addr%0d: got %02h expected %02h", i, addrs[i], ea); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen_busy;
        int hs0;
        set_cfg(0, 'h10, 3); bus.tx_ready = 1'b0;
        pulse(4'b0001);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus.tx_valid) ok = 1'b1;
        end
        pulse(4'b0100);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || grant !== '0 || done !== 1'b0)
            begin bad++; $display("FAIL rmid_abort: got v=%b busy=%b grant=%b done=%b expected all 0", bus.tx_valid, busy, grant, done); end
        rst = 1'b0;
        seen_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL rmid_pending: got busy after reset, expected pending cleared"); end
        bus.tx_ready = 1'b1; hs0 = hs_cnt;
        pulse(4'b0001);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus.tx_valid) ok = 1'b1;
        end
        total++; if (!ok || bus.tx_data !== rom[16]) begin bad++; $display("FAIL rmid_first_byte: got %02h expected %02h", bus.tx_data, rom[16]); end
        wait_idle(40, ok);
        total++; if (!ok || hs_cnt - hs0 != 3) begin bad++; $display("FAIL rmid_count: got hs=%0d expected 3", hs_cnt - hs0); end
    endtask

    task automatic test_random();
        bit ok, left;
        int g0, d0;
        for (int i = 0; i < N; i++) set_cfg(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 5)));
        g0 = grant_cnt; d0 = done_cnt;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            req = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            bus.tx_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); req = '0; bus.tx_ready = 1'b1;
        wait_idle(600, ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_drain: got busy=%b expected idle", busy); end
        left = 1'b0;
        for (int i = 0; i < N; i++) if (m_pend[i]) left = 1'b1;
        total++; if (left) begin bad++; $display("FAIL rnd_dropped_request: got idle, expected pending work"); end
        total++; if (grant_cnt - g0 != done_cnt - d0 || grant_cnt - g0 < 10)
            begin bad++; $display("FAIL rnd_counts: got grants=%0d dones=%0d expected equal and >=10", grant_cnt - g0, done_cnt - d0); end
    endtask

    initial begin
        rst = 1'b1; req = '0; bus.tx_ready = 1'b0;
        msg_base = '0; msg_len = '0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[16] = 8'h32; rom[17] = 8'h30; rom[18] = 8'h30;
        for (int i = 0; i < N; i++) set_cfg(i, 16 * i, 1);
        test_reset();
        test_single();
        test_backpressure();
        test_simultaneous();
        test_fairness();
        test_edge();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
